// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and helpers for the register write arbiter.
// Two-state ownership FSM, index width helper, clear data value.
package reg_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_e;

    // Replicated across the word width to form the all-zeros clear write.
    localparam logic CLR_VALUE = 1'b0;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester-side bundle of the register write arbiter: requests, lock, data, clear in;
// grants, bank enable/data, busy and owner out.
interface reg_write_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    import reg_arb_pkg::*;

    localparam int IW = idx_w(NUM_REQ);

    logic [NUM_REQ-1:0]       REQ;
    logic [NUM_REQ-1:0]       LOCK;
    logic [NUM_REQ*WIDTH-1:0] DIN;
    logic                     CLR;
    logic [NUM_REQ-1:0]       GNT;
    logic                     E;
    logic [WIDTH-1:0]         D;
    logic                     BUSY;
    logic [IW-1:0]            OWNER;

    modport master (
        output REQ, LOCK, DIN, CLR,
        input  GNT, E, D, BUSY, OWNER
    );

    modport slave (
        input  REQ, LOCK, DIN, CLR,
        output GNT, E, D, BUSY, OWNER
    );

endinterface

// File: rtl/reg_write_arbiter_rr_pick.sv
// Round-robin picker: first set req bit at or after ptr, wrapping.
// Purely combinational; no backpressure.
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IW      = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] win,
    output logic [IW-1:0]      win_idx,
    output logic               any_req
);

    always_comb begin
        int idx;
        win     = '0;
        win_idx = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(ptr) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_req && req[idx]) begin
                any_req      = 1'b1;
                win[idx]     = 1'b1;
                win_idx      = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Arbitrates NUM_REQ writers onto one enable-gated register word (round-robin, locked bursts, clear).
// Latency: 1 cycle from REQ/CLR sample to registered E/D/GNT. No backpressure; losers simply retry.
// Option: REG_ARB_FIXED_PRIO_EN gives requester 0 absolute priority in IDLE.
module reg_write_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                C,
    input  logic                R,
    reg_write_arbiter_if.slave  bus
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int HW = 8;

    state_e             state;
    logic [IW-1:0]      ptr;
    logic [IW-1:0]      owner;
    logic [HW-1:0]      hold;
    logic [NUM_REQ-1:0] gnt;
    logic               e;
    logic [WIDTH-1:0]   d;

    logic [IW-1:0]      pick_ptr;
    logic [NUM_REQ-1:0] win;
    logic [IW-1:0]      win_idx;
    logic               any_req;
    logic [IW-1:0]      ptr_adv;
    logic [NUM_REQ-1:0] owner_oh;
    logic [WIDTH-1:0]   win_dat;
    logic [WIDTH-1:0]   owner_dat;

`ifdef REG_ARB_FIXED_PRIO_EN
    // Starting the search at 0 makes requester 0 win whenever it asks.
    assign pick_ptr = bus.REQ[0] ? '0 : ptr;
`else
    assign pick_ptr = ptr;
`endif

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req     (bus.REQ),
        .ptr     (pick_ptr),
        .win     (win),
        .win_idx (win_idx),
        .any_req (any_req)
    );

    always_comb begin
        ptr_adv         = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
        owner_oh        = '0;
        owner_oh[owner] = 1'b1;
        win_dat         = bus.DIN[int'(win_idx)*WIDTH +: WIDTH];
        owner_dat       = bus.DIN[int'(owner)*WIDTH +: WIDTH];
    end

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
            hold  <= '0;
            gnt   <= '0;
            e     <= 1'b0;
            d     <= '0;
        end else begin
            gnt <= '0;
            e   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.CLR) begin
                        e <= 1'b1;
                        d <= {WIDTH{CLR_VALUE}};
                    end else if (any_req) begin
                        gnt   <= win;
                        e     <= 1'b1;
                        d     <= win_dat;
                        owner <= win_idx;
                        ptr   <= ptr_adv;
                        if (bus.LOCK[win_idx]) begin
                            state <= OWN;
                            hold  <= HW'(1);
                        end
                    end
                end
                default: begin
                    // Owner-only service; ptr already points past the owner.
                    if (bus.CLR) begin
                        e     <= 1'b1;
                        d     <= {WIDTH{CLR_VALUE}};
                        state <= IDLE;
                        hold  <= '0;
                    end else if (!bus.LOCK[owner]) begin
                        state <= IDLE;
                        hold  <= '0;
                        if (bus.REQ[owner]) begin
                            gnt <= owner_oh;
                            e   <= 1'b1;
                            d   <= owner_dat;
                        end
                    end else if (hold == HW'(MAX_HOLD)) begin
                        state <= IDLE;
                        hold  <= '0;
                    end else begin
                        hold <= hold + 1'b1;
                        if (bus.REQ[owner]) begin
                            gnt <= owner_oh;
                            e   <= 1'b1;
                            d   <= owner_dat;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.GNT   = gnt;
    assign bus.E     = e;
    assign bus.D     = d;
    assign bus.BUSY  = (state == OWN);
    assign bus.OWNER = owner;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboarded bench for reg_write_arbiter: spec-level reference model plus directed grant sequences.
module tb_reg_write_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MH = 4;
    localparam int IW = $clog2(N);

    logic C;
    logic R;

    reg_write_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

    reg_write_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
        .C   (C),
        .R   (R),
        .bus (bus)
    );

    typedef struct packed {
        logic          e;
        logic [W-1:0]  d;
        logic [N-1:0]  gnt;
        logic          busy;
        logic [IW-1:0] owner;
    } exp_t;

    exp_t         exp_q[$];
    logic [N-1:0] gnt_hist[$];
    logic         busy_hist[$];
    logic [W-1:0] d_hist[$];

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int           m_ptr;
    int           m_owner;
    int           m_hold;
    bit           m_own;
    logic [W-1:0] m_d;

    initial C = 1'b0;
    always #5 C = ~C;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_owner = 0;
        m_hold  = 0;
        m_own   = 1'b0;
        m_d     = '0;
    endtask

    function automatic int rr_winner(input logic [N-1:0] req);
`ifdef REG_ARB_FIXED_PRIO_EN
        if (req[0]) return 0;
`endif
        for (int k = 0; k < N; k++) begin
            if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [N-1:0] req, input logic [N-1:0] lock, input logic clr,
                              input logic [N*W-1:0] din, output exp_t x);
        int  w;
        bit  serve_owner;
        x           = '0;
        serve_owner = 1'b0;
        if (!m_own) begin
            if (clr) begin
                x.e = 1'b1;
                m_d = '0;
            end else begin
                w = rr_winner(req);
                if (w >= 0) begin
                    x.e      = 1'b1;
                    x.gnt[w] = 1'b1;
                    m_d      = din[w*W +: W];
                    m_owner  = w;
                    m_ptr    = (w + 1) % N;
                    if (lock[w]) begin
                        m_own  = 1'b1;
                        m_hold = 1;
                    end
                end
            end
        end else begin
            if (clr) begin
                x.e   = 1'b1;
                m_d   = '0;
                m_own = 1'b0;
            end else if (!lock[m_owner]) begin
                m_own       = 1'b0;
                serve_owner = req[m_owner];
            end else if (m_hold == MH) begin
                m_own = 1'b0;
            end else begin
                m_hold      = m_hold + 1;
                serve_owner = req[m_owner];
            end
            if (serve_owner) begin
                x.e            = 1'b1;
                x.gnt[m_owner] = 1'b1;
                m_d            = din[m_owner*W +: W];
            end
        end
        x.d     = m_d;
        x.busy  = m_own;
        x.owner = IW'(m_owner);
    endtask

    task automatic cycle_din(input logic [N-1:0] req, input logic [N-1:0] lock, input logic clr,
                             input logic [N*W-1:0] din);
        exp_t x;
        @(negedge C);
        R        = 1'b1;
        bus.REQ  = req;
        bus.LOCK = lock;
        bus.CLR  = clr;
        bus.DIN  = din;
        model_step(req, lock, clr, din, x);
        exp_q.push_back(x);
    endtask

    task automatic cycle(input logic [N-1:0] req, input logic [N-1:0] lock, input logic clr);
        cycle_din(req, lock, clr, (N*W)'($urandom));
    endtask

    // One idle cycle keeps model and DUT aligned, then every expectation has been consumed.
    task automatic drain();
        cycle(4'b0000, 4'b0000, 1'b0);
        @(posedge C);
        #2;
        check("DRAIN_EMPTY", exp_q.size(), 0);
    endtask

    task automatic async_reset();
        @(posedge C);
        #2;
        R = 1'b0;
        #1;
        check("ARST_E", int'(bus.E), 0);
        check("ARST_GNT", int'(bus.GNT), 0);
        check("ARST_D", int'(bus.D), 0);
        check("ARST_BUSY", int'(bus.BUSY), 0);
        check("ARST_OWNER", int'(bus.OWNER), 0);
        model_reset();
    endtask

    task automatic check_gnt_seq(input string name, input int base, input int n, input logic [31:0] seq);
        int act;
        for (int i = 0; i < n; i++) begin
            act = (base + i < gnt_hist.size()) ? int'(gnt_hist[base + i]) : -1;
            check($sformatf("%s_GNT%0d", name, i), act, int'(seq[4*i +: 4]));
        end
    endtask

    task automatic check_busy_seq(input string name, input int base, input int n, input logic [7:0] seq);
        int act;
        for (int i = 0; i < n; i++) begin
            act = (base + i < busy_hist.size()) ? int'(busy_hist[base + i]) : -1;
            check($sformatf("%s_BUSY%0d", name, i), act, int'(seq[i]));
        end
    endtask

    // Monitor: one expectation per clock, compared just after the edge.
    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge C);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("E", int'(bus.E), int'(x.e));
                check("D", int'(bus.D), int'(x.d));
                check("GNT", int'(bus.GNT), int'(x.gnt));
                check("BUSY", int'(bus.BUSY), int'(x.busy));
                check("OWNER", int'(bus.OWNER), int'(x.owner));
                gnt_hist.push_back(bus.GNT);
                busy_hist.push_back(bus.BUSY);
                d_hist.push_back(bus.D);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base;
        R        = 1'b1;
        bus.REQ  = '0;
        bus.LOCK = '0;
        bus.CLR  = 1'b0;
        bus.DIN  = '0;
        model_reset();
        #2 R = 1'b0;
        #1;
        check("RST_E", int'(bus.E), 0);
        check("RST_GNT", int'(bus.GNT), 0);
        check("RST_D", int'(bus.D), 0);
        check("RST_BUSY", int'(bus.BUSY), 0);
        check("RST_OWNER", int'(bus.OWNER), 0);
        repeat (2) @(negedge C);

        // Single write from requester 0
        base = gnt_hist.size();
        cycle_din(4'b0001, 4'b0000, 1'b0, 32'h5A3C_C3A5);
        drain();
        check_gnt_seq("SINGLE", base, 1, 32'h1);
        check("SINGLE_D", (base < d_hist.size()) ? int'(d_hist[base]) : -1, 8'hA5);
        async_reset();

`ifdef REG_ARB_FIXED_PRIO_EN
        base = gnt_hist.size();
        repeat (4) cycle(4'b1101, 4'b0000, 1'b0);
        repeat (4) cycle(4'b1100, 4'b0000, 1'b0);
        drain();
        check_gnt_seq("FIXED", base, 8, 32'h8484_1111);
`else
        base = gnt_hist.size();
        repeat (8) cycle(4'b1111, 4'b0000, 1'b0);
        drain();
        check_gnt_seq("RR", base, 8, 32'h8421_8421);

        base = gnt_hist.size();
        repeat (4) cycle(4'b0110, 4'b0010, 1'b0);
        repeat (2) cycle(4'b0110, 4'b0000, 1'b0);
        drain();
        check_gnt_seq("LOCK", base, 6, 32'h0042_2222);
        check_busy_seq("LOCK", base, 6, 8'b0000_1111);

        base = gnt_hist.size();
        cycle(4'b0100, 4'b0100, 1'b0);
        repeat (4) cycle(4'b1100, 4'b0100, 1'b0);
        cycle(4'b1100, 4'b0000, 1'b0);
        drain();
        check_gnt_seq("TMO", base, 6, 32'h0080_4444);

        base = gnt_hist.size();
        cycle(4'b1111, 4'b0000, 1'b1);
        cycle(4'b1111, 4'b0000, 1'b0);
        repeat (2) cycle(4'b0010, 4'b0010, 1'b0);
        cycle(4'b1111, 4'b0010, 1'b1);
        cycle(4'b1111, 4'b0000, 1'b0);
        drain();
        check_gnt_seq("CLR", base, 6, 32'h0040_2210);
        check_busy_seq("CLR", base, 6, 8'b0000_1100);
        check("CLR_D", (base + 4 < d_hist.size()) ? int'(d_hist[base + 4]) : -1, 0);
`endif

        // Randomized traffic, locks held often enough to reach the hold limit
        for (int i = 0; i < 400; i++) begin
            if (i % 100 == 60) async_reset();
            cycle(4'($urandom_range(0, 15)),
                  4'($urandom) | 4'($urandom),
                  ($urandom_range(0, 15) == 0));
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
